// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit framer and receive path.
//   - tx_state_e : transmit framer state encoding
//   - line level constants (start, stop, idle)
//   - parity type encoding (shared with the receiver's parity check)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: parallel request side and serial output of the UART framer.
//   p_data/data_valid/par_en/par_typ : request from upstream (master -> slave)
//   tx_out/busy                      : registered serial line and frame-active flag
interface uart_tx_frame_if #(
  parameter int frame_data = 8
) ();
  logic [frame_data-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (output p_data, data_valid, par_en, par_typ, input tx_out, busy);
  modport slave  (input p_data, data_valid, par_en, par_typ, output tx_out, busy);
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity bit generator, shared with the receive path.
//   i_data    : data word
//   i_par_typ : PAR_EVEN / PAR_ODD
//   o_par     : parity bit that makes the total count of ones even/odd
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int frame_data = 8
) (
  input  logic [frame_data-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par
);
  logic w_xor;
  assign w_xor = ^i_data;
  assign o_par = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer, one serial bit per clk cycle.
//   clk : transmit baud clock
//   rst : asynchronous active-low reset
//   bus : slave side of uart_tx_frame_if (request in, tx_out/busy out)
// Frame: start, frame_data bits LSB first, optional parity, stop.
// Outputs come straight from flops; requests while busy are dropped.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int frame_data = 8,
  parameter int bit_cnt_w  = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  bus
);
  localparam logic [bit_cnt_w-1:0] LAST_BIT = bit_cnt_w'(frame_data - 1);

  tx_state_e             r_state,    w_state_nx;
  logic                  r_tx,       w_tx_nx;
  logic                  r_busy,     w_busy_nx;
  logic [bit_cnt_w-1:0]  r_cnt,      w_cnt_nx;
  logic [frame_data-1:0] r_data,     w_data_nx;
  logic [frame_data-1:0] r_shift,    w_shift_nx;
  logic                  r_par_en,   w_par_en_nx;
  logic                  r_par_typ,  w_par_typ_nx;
  logic                  w_par;

  // Parity taken from the latched word, so mid-frame input changes cannot leak in.
  uart_parity_calc #(.frame_data(frame_data)) u_par (
    .i_data    (r_data),
    .i_par_typ (r_par_typ),
    .o_par     (w_par)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_shift   <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_tx      <= w_tx_nx;
      r_busy    <= w_busy_nx;
      r_cnt     <= w_cnt_nx;
      r_data    <= w_data_nx;
      r_shift   <= w_shift_nx;
      r_par_en  <= w_par_en_nx;
      r_par_typ <= w_par_typ_nx;
    end
  end

  // Next-state and next-output logic; tx/busy are computed one edge ahead
  // so the flops present the bit for the state being entered.
  always_comb begin
    w_state_nx   = r_state;
    w_tx_nx      = r_tx;
    w_busy_nx    = r_busy;
    w_cnt_nx     = r_cnt;
    w_data_nx    = r_data;
    w_shift_nx   = r_shift;
    w_par_en_nx  = r_par_en;
    w_par_typ_nx = r_par_typ;
    case (r_state)
      IDLE: begin
        w_tx_nx   = IDLE_LEVEL;
        w_busy_nx = 1'b0;
        if (bus.data_valid) begin
          w_data_nx    = bus.p_data;
          w_shift_nx   = bus.p_data;
          w_par_en_nx  = bus.par_en;
          w_par_typ_nx = bus.par_typ;
          w_state_nx   = START;
          w_tx_nx      = START_BIT;
          w_busy_nx    = 1'b1;
        end
      end
      START: begin
        w_state_nx = DATA;
        w_tx_nx    = r_shift[0];
        w_shift_nx = {1'b0, r_shift[frame_data-1:1]};
        w_cnt_nx   = '0;
      end
      DATA: begin
        if (r_cnt == LAST_BIT) begin
          if (r_par_en) begin
            w_state_nx = PARITY;
            w_tx_nx    = w_par;
          end else begin
            w_state_nx = STOP;
            w_tx_nx    = STOP_BIT;
          end
        end else begin
          w_cnt_nx   = r_cnt + bit_cnt_w'(1);
          w_tx_nx    = r_shift[0];
          w_shift_nx = {1'b0, r_shift[frame_data-1:1]};
        end
      end
      PARITY: begin
        w_state_nx = STOP;
        w_tx_nx    = STOP_BIT;
      end
      STOP: begin
        w_state_nx = IDLE;
        w_tx_nx    = IDLE_LEVEL;
        w_busy_nx  = 1'b0;
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = IDLE_LEVEL;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign bus.tx_out = r_tx;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
  // bits[i] is the expected tx_out in busy cycle i (leftmost literal bit = cycle 0).
  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        pt;
    logic [3:0]  len;
    logic [0:10] bits;
  } vec_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs [7];

  uart_tx_frame_if #(.frame_data(8)) bus ();

  uart_tx_frame #(.frame_data(8), .bit_cnt_w(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " tx"}, bus.tx_out, 1'b1);
    chk({nm, " busy"}, bus.busy, 1'b0);
  endtask

  // Called at a negedge while idle; returns at the negedge of busy cycle 0.
  task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  // Checks len busy cycles; returns at the negedge following the last one.
  task automatic chk_frame(input string nm, input logic [0:10] bits, input int len, input bit disturb);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", nm, i), bus.tx_out, bits[i]);
      chk($sformatf("%s busy[%0d]", nm, i), bus.busy, 1'b1);
      if (disturb && i == 3) begin
        bus.p_data     = 8'hFF;
        bus.data_valid = 1'b1;
        bus.par_typ    = 1'b1;
      end
      if (disturb && i == 4) bus.data_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, len: 4'd10, bits: 11'b01010010111};
    vecs[1] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, len: 4'd11, bits: 11'b01010010101};
    vecs[2] = '{d: 8'hA5, pe: 1'b1, pt: 1'b1, len: 4'd11, bits: 11'b01010010111};
    vecs[3] = '{d: 8'h07, pe: 1'b1, pt: 1'b0, len: 4'd11, bits: 11'b01110000011};
    vecs[4] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, len: 4'd11, bits: 11'b01110000001};
    vecs[5] = '{d: 8'h00, pe: 1'b0, pt: 1'b0, len: 4'd10, bits: 11'b00000000011};
    vecs[6] = '{d: 8'hFF, pe: 1'b1, pt: 1'b1, len: 4'd11, bits: 11'b01111111111};

    rst            = 1'b0;
    bus.p_data     = 8'h00;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;

    // Held in reset with requests toggling: line stays idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle($sformatf("in_reset%0d", i));
      bus.data_valid = ~bus.data_valid;
    end
    @(negedge clk);
    bus.data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // Table of single frames.
    for (int v = 0; v < 7; v++) begin
      launch(vecs[v].d, vecs[v].pe, vecs[v].pt);
      chk_frame($sformatf("vec%0d", v), vecs[v].bits, int'(vecs[v].len), 1'b0);
      chk_idle($sformatf("vec%0d_after", v));
      @(negedge clk);
    end

    // Mid-frame input changes are ignored: 0x3C even parity -> 0 00111100 0 1.
    launch(8'h3C, 1'b1, 1'b0);
    chk_frame("midchg", 11'b00011110001, 11, 1'b1);
    chk_idle("midchg_after");
    bus.par_typ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("midchg_noframe%0d", i));
    end

    // Back-to-back with data_valid held: one idle cycle between frames.
    bus.p_data     = 8'h55;
    bus.par_en     = 1'b0;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.p_data = 8'hAA;
    chk_frame("b2b_55", 11'b01010101011, 10, 1'b0);
    chk_idle("b2b_gap");
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk_frame("b2b_AA", 11'b00101010111, 10, 1'b0);
    chk_idle("b2b_after");
    @(negedge clk);

    // Asynchronous reset during d3 of 0xA5 (d3 = 0).
    launch(8'hA5, 1'b0, 1'b0);
    chk_frame("pre_rst", 11'b01010010111, 4, 1'b0);
    chk("at_d3 tx", bus.tx_out, 1'b0);
    #2 rst = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst_release%0d", i));
    end
    launch(8'hA5, 1'b1, 1'b0);
    chk_frame("after_rst", 11'b01010010101, 11, 1'b0);
    chk_idle("after_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
